// File: rtl/image_rotate_ctrl.sv
// image_rotate_ctrl: buffers one frame into external RAM, either in raster
// order or transposed so that a linear read-back produces the image rotated
// 90 degrees clockwise, then streams the frame back out of RAM with framing.
module image_rotate_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_SZ   = 20,
  parameter int RAM_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 start_in,
  input  logic                 valid_in,
  input  logic [23:0]          data_in,
  input  logic                 jump_in,
  output logic [ADDR_SZ-1:0]   ram_addr,
  output logic                 ram_we,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  input  logic [RAM_WIDTH-1:0] ram_rdata,
  output logic                 start_out,
  output logic [23:0]          data_out,
  output logic                 valid_out,
  output logic                 jump_out,
  output logic                 busy,
  output logic                 err
);

  // The frame must fit in the RAM address space.
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_SZ)) begin : g_param_err
    $error("image_rotate_ctrl: IMG_W*IMG_H exceeds 2**ADDR_SZ");
  end

  localparam logic [ADDR_SZ-1:0] TOTAL_M1 = ADDR_SZ'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_SZ-1:0] COL_LAST = ADDR_SZ'(IMG_W - 1);
  localparam logic [ADDR_SZ-1:0] ROT_BASE = ADDR_SZ'(IMG_H - 1);
  localparam logic [ADDR_SZ-1:0] ROT_STEP = ADDR_SZ'(IMG_H);
  localparam logic [ADDR_SZ-1:0] LIN_LINE = ADDR_SZ'(IMG_W);
  localparam logic [ADDR_SZ-1:0] ONE      = ADDR_SZ'(1);
  localparam logic [ADDR_SZ-1:0] OLR_LAST = ADDR_SZ'(IMG_H - 1);
  localparam logic [ADDR_SZ-1:0] OLP_LAST = ADDR_SZ'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  // Write-side tracking: column, pixel count, current line base and the
  // address of the next incoming pixel (all stepped incrementally).
  logic               mode_lat;
  logic [ADDR_SZ-1:0] col;
  logic [ADDR_SZ-1:0] pix_cnt;
  logic [ADDR_SZ-1:0] line_base;
  logic [ADDR_SZ-1:0] pix_addr;

  // Read-side tracking.
  logic [ADDR_SZ-1:0] rd_addr;
  logic               rd_issued;
  logic [ADDR_SZ-1:0] out_col;
  logic               out_first;

  logic               accept_start;
  logic               wr_pix;
  logic               cur_mode;
  logic [ADDR_SZ-1:0] cur_col;
  logic [ADDR_SZ-1:0] cur_cnt;
  logic [ADDR_SZ-1:0] cur_base;
  logic [ADDR_SZ-1:0] cur_addr;
  logic [ADDR_SZ-1:0] next_base;
  logic [ADDR_SZ-1:0] next_addr;
  logic [ADDR_SZ-1:0] out_last;
  logic               line_end;
  logic               last_pix;
  logic               fmt_err;
  logic               unused_rdata_hi;

  assign unused_rdata_hi = ^ram_rdata[RAM_WIDTH-1:24];
  assign busy            = (state != IDLE);

  // Current-pixel context; an accepted start pixel is treated as (0,0) using the live mode.
  always_comb begin
    accept_start = (state == IDLE) && valid_in && start_in;
    wr_pix       = accept_start || ((state == WRITE) && valid_in);
    cur_mode     = mode_lat;
    cur_col      = col;
    cur_cnt      = pix_cnt;
    cur_base     = line_base;
    cur_addr     = pix_addr;
    if (state != WRITE) begin
      cur_mode = mode;
      cur_col  = '0;
      cur_cnt  = '0;
      cur_base = mode ? ROT_BASE : '0;
      cur_addr = mode ? ROT_BASE : '0;
    end else begin
      cur_mode = mode_lat;
    end
    line_end  = (cur_col == COL_LAST);
    last_pix  = (cur_cnt == TOTAL_M1);
    fmt_err   = wr_pix && ((jump_in != line_end) || ((state == WRITE) && start_in));
    next_base = cur_mode ? (cur_base - ONE) : (cur_base + LIN_LINE);
    if (line_end) begin
      next_addr = next_base;
    end else begin
      next_addr = cur_addr + (cur_mode ? ROT_STEP : ONE);
    end
    out_last = mode_lat ? OLR_LAST : OLP_LAST;
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and RAM-side outputs (writes are combinational with the pixel).
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_addr   = '0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          if (fmt_err) begin
            state_next = IDLE;
          end else if (last_pix) begin
            state_next = READ;
          end else begin
            state_next = WRITE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (valid_in) begin
          if (fmt_err) begin
            state_next = IDLE;
          end else if (last_pix) begin
            state_next = READ;
          end else begin
            state_next = WRITE;
          end
        end else begin
          state_next = WRITE;
        end
      end
      READ: begin
        ram_addr = rd_addr;
        if (rd_addr == TOTAL_M1) begin
          state_next = DRAIN;
        end else begin
          state_next = READ;
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (wr_pix) begin
      ram_we    = 1'b1;
      ram_wdata = RAM_WIDTH'(data_in);
      ram_addr  = cur_addr;
    end else begin
      ram_we = 1'b0;
    end
  end

  // Write-side counters: advance on every written pixel, clear on a format error.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mode_lat  <= 1'b0;
      col       <= '0;
      pix_cnt   <= '0;
      line_base <= '0;
      pix_addr  <= '0;
    end else begin
      if (accept_start) begin
        mode_lat <= mode;
      end
      if (wr_pix && !fmt_err) begin
        col       <= line_end ? '0 : (cur_col + ONE);
        pix_cnt   <= cur_cnt + ONE;
        line_base <= line_end ? next_base : cur_base;
        pix_addr  <= next_addr;
      end else if (wr_pix) begin
        col       <= '0;
        pix_cnt   <= '0;
        line_base <= '0;
        pix_addr  <= '0;
      end
    end
  end

  // Sticky error flag: set by a format error, cleared by the next accepted start.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (fmt_err) begin
      err <= 1'b1;
    end else if (accept_start) begin
      err <= 1'b0;
    end
  end

  // Read address counter; also remembers that a read was issued last cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_issued <= 1'b0;
    end else begin
      rd_issued <= (state == READ);
      if ((state == READ) && (rd_addr != TOTAL_M1)) begin
        rd_addr <= rd_addr + ONE;
      end else begin
        rd_addr <= '0;
      end
    end
  end

  // Output stage: register RAM read data with its framing flags.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      start_out <= 1'b0;
      jump_out  <= 1'b0;
      out_col   <= '0;
      out_first <= 1'b1;
    end else begin
      valid_out <= rd_issued;
      start_out <= rd_issued && out_first;
      jump_out  <= rd_issued && (out_col == out_last);
      data_out  <= rd_issued ? ram_rdata[23:0] : 24'h000000;
      if (rd_issued) begin
        out_first <= 1'b0;
        out_col   <= (out_col == out_last) ? '0 : (out_col + ONE);
      end else if ((state == IDLE) || (state == WRITE)) begin
        out_first <= 1'b1;
        out_col   <= '0;
      end
    end
  end

endmodule
